// File: rtl/serial_wide_adder_ctrl.sv
// Word-serial wide adder: adds two NUM_WORDS*WORD_BITS operands one slice per cycle
// through a single adder_nbit. Define SIGNED_OVF_EN for two's-complement overflow.
module serial_wide_adder_ctrl #(
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned WORD_BITS = 4
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start,
  input  logic [NUM_WORDS*WORD_BITS-1:0] a,
  input  logic [NUM_WORDS*WORD_BITS-1:0] b,
  input  logic                           carry_in,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_WORDS*WORD_BITS-1:0] sum,
  output logic                           overflow
);

  localparam int unsigned W        = NUM_WORDS * WORD_BITS;
  localparam int unsigned IDX_BITS = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                state, state_next;
  logic [W-1:0]          op_a, op_b;
  logic [W-WORD_BITS-1:0] partial;
  logic                  carry_reg;
  logic [IDX_BITS-1:0]   idx;
  logic                  last_word;

  logic [WORD_BITS-1:0]  add_a, add_b, add_sum;
  logic                  add_cin, add_cout;
  logic [W-1:0]          result_next;
  logic                  ovf_next;

  // Operands shift right each ADD cycle so the current word is always the low slice.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == ADD) begin
      add_a   = op_a[WORD_BITS-1:0];
      add_b   = op_b[WORD_BITS-1:0];
      add_cin = carry_reg;
    end
  end

  adder_nbit #(.N(WORD_BITS)) u_adder (
    .a        (add_a),
    .b        (add_b),
    .carry_in (add_cin),
    .sum      (add_sum),
    .overflow (add_cout)
  );

  assign last_word   = (idx == IDX_BITS'(NUM_WORDS - 1));
  assign result_next = {add_sum, partial};

`ifdef SIGNED_OVF_EN
  // On the last word the low slices of op_a/op_b hold the operand MSWs.
  assign ovf_next = (op_a[WORD_BITS-1] == op_b[WORD_BITS-1]) &&
                    (add_sum[WORD_BITS-1] != op_a[WORD_BITS-1]);
`else
  assign ovf_next = add_cout;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last_word) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ADD);
      done  <= (state_next == DONE);
    end
  end

  // Datapath: operand capture, carry chain and result accumulation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op_a      <= '0;
      op_b      <= '0;
      partial   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a      <= a;
            op_b      <= b;
            carry_reg <= carry_in;
            idx       <= '0;
          end
        end
        ADD: begin
          op_a      <= op_a >> WORD_BITS;
          op_b      <= op_b >> WORD_BITS;
          carry_reg <= add_cout;
          partial   <= result_next[W-1:WORD_BITS];
          idx       <= idx + IDX_BITS'(1);
          if (last_word) begin
            sum      <= result_next;
            overflow <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// Single ripple slice shared by the sequencer; overflow is the carry out.
module adder_nbit #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         overflow
);

  assign {overflow, sum} = (N+1)'(a) + (N+1)'(b) + (N+1)'(carry_in);

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// Directed self-checking bench for serial_wide_adder_ctrl (16-bit default build).
module tb_serial_wide_adder_ctrl;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [15:0] a, b;
  logic        carry_in;
  logic        busy, done, overflow;
  logic [15:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  serial_wide_adder_ctrl #(.NUM_WORDS(4), .WORD_BITS(4)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h1111; carry_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({busy, done, sum, overflow} !== 19'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: busy=%b done=%b sum=%h ovf=%b, want all 0", i, busy, done, sum, overflow);
      end
    end
    start = 1'b0;
    #2 n_rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    a = 16'h1234; b = 16'h1111; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_busy cyc%0d: busy=%b done=%b, want 1 0", i, busy, done);
      end
      if (i < 3) tick();
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== 16'h2345 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b sum=%h ovf=%b, want 1 0 2345 0", done, busy, sum, overflow);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || sum !== 16'h2345 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: done=%b sum=%h ovf=%b, want 0 2345 0", done, sum, overflow);
    end
  endtask

  task automatic test_carry_ripple();
    logic exp_ovf;
`ifdef SIGNED_OVF_EN
    exp_ovf = 1'b0;
`else
    exp_ovf = 1'b1;
`endif
    a = 16'hFFFF; b = 16'h0000; carry_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; carry_in = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h0000 || overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL carry_ripple: done=%b sum=%h ovf=%b, want 1 0000 %b", done, sum, overflow, exp_ovf);
    end
    tick();
  endtask

  task automatic test_ignore_busy();
    int dones = 0;
    a = 16'h00F0; b = 16'h0010; carry_in = 1'b0; start = 1'b1;
    tick();
    a = 16'hAAAA; b = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_idle: busy=%b done=%b, want 0 0", busy, done);
    end
    repeat (6) begin
      tick();
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 1 || sum !== 16'h0100 || overflow !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: dones=%0d sum=%h ovf=%b busy=%b, want 1 0100 0 0", dones, sum, overflow, busy);
    end
  endtask

  task automatic test_reset_mid();
    a = 16'h8888; b = 16'h8888; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, overflow} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h ovf=%b, want all 0", busy, done, sum, overflow);
    end
    tick();
    n_rst = 1'b1;
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h0003 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: done=%b sum=%h ovf=%b, want 1 0003 0", done, sum, overflow);
    end
    tick();
  endtask

  task automatic test_signed_boundary();
    logic exp_ovf;
`ifdef SIGNED_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    a = 16'h7FFF; b = 16'h0001; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h8000 || overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL signed_boundary: done=%b sum=%h ovf=%b, want 1 8000 %b", done, sum, overflow, exp_ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    a = 16'h0F0F; b = 16'h0101; carry_in = 1'b0; start = 1'b1;
    tick();
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h1010) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b sum=%h, want 1 1010", done, sum);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b, want 0 0", busy, done);
    end
    a = 16'h1000; b = 16'h2000; carry_in = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_retrigger: busy=%b, want 1", busy);
    end
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h3001 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b sum=%h ovf=%b, want 1 3001 0", done, sum, overflow);
    end
    tick();
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_ignore_busy();
    test_reset_mid();
    test_signed_boundary();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_wide_adder_ctrl.md
Name: serial_wide_adder_ctrl

Overview:
- Sequencer that adds two NUM_WORDS×WORD_BITS-bit operands over several cycles using one adder_nbit instance (4-bit a/b, carry_in, sum, overflow = carry out).
- Processes one word per cycle, least significant word first, and chains the carry through a register.
- Captures the final result and pulses done.
- Sits between a requesting block and the shared adder datapath; it is the only driver of the adder inputs.

Parameters:
- NUM_WORDS, 4, number of words per operand (≥2); operand width W = NUM_WORDS*WORD_BITS.
- WORD_BITS, 4, width of one adder slice; must equal the adder_nbit width (4).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  W  operand A, captured on accepted start.
- b  input  W  operand B, captured on accepted start.
- carry_in  input  1  initial carry, captured on accepted start.
- busy  output  1  high while an addition is in progress (ADD state).
- done  output  1  one-cycle pulse when result registers update.
- sum  output  W  registered result, held until the next completion.
- overflow  output  1  registered overflow flag, held with sum.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (n_rst).
- Reset (n_rst=0, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, overflow=0.
  - Operand, carry and word-index registers cleared.
  - An in-flight addition is discarded.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0, done=0.
  - At a rising edge with start=1: capture a, b, carry_in into opA/opB/carry_reg; idx=0; go to ADD.
  - start=0: stay.
- ADD:
  - busy=1.
  - Adder inputs: a=opA word[idx], b=opB word[idx], carry_in=carry_reg.
  - Each edge: store adder sum into partial word[idx]; carry_reg <= adder carry out; idx++.
  - When idx==NUM_WORDS-1 at the edge: load sum <= full partial result (including the word written this edge), overflow <= final carry out (see Optional Feature); go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle; next edge always goes to IDLE.
  - start in DONE is ignored; no back-to-back acceptance.
- Latency: start-accept edge → done high after NUM_WORDS+1 rising edges; 16-bit default: busy high 4 cycles, done on the 5th.
- start while busy or in DONE is ignored. Operands changing after acceptance have no effect.
- Held start in IDLE re-triggers a new operation on every return to IDLE.
- Arithmetic: unsigned modulo 2^W. The carry between words is exactly the adder carry out. carry_in enters only word 0.
- Adder inputs in IDLE/DONE are driven 0 (deterministic, no X).
- sum/overflow change only on entry to DONE or on reset.

Optional Feature:
- Macro SIGNED_OVF_EN.
- Defined: overflow = two's-complement signed overflow of the W-bit add, computed from captured operand MSBs and the result MSB: (opA[W-1]==opB[W-1]) && (result[W-1]!=opA[W-1]). carry_in is included in the result.
- Undefined: overflow = unsigned carry out of the most significant word.
- sum and timing are identical in both builds.

Test Plan:
- Reset: hold n_rst=0 for 2 cycles with start=1 → busy=0, done=0, sum=0x0000, overflow=0 throughout; no operation begins until n_rst=1.
- a=0x1234, b=0x1111, carry_in=0, start pulse → busy=1 for 4 cycles, done=1 on 5th edge, sum=0x2345, overflow=0, values held after done falls.
- a=0xFFFF, b=0x0000, carry_in=1 → carry ripples through all 4 words; sum=0x0000, overflow=1 (unsigned build).
- Accept a=0x00F0, b=0x0010, then assert start with a=0xAAAA, b=0x5555 during busy and DONE → second request ignored; sum=0x0100; done pulses once.
- Start a=0x8888, b=0x8888, drop n_rst at second ADD cycle → outputs 0 immediately, state IDLE; new start a=0x0001, b=0x0002 → sum=0x0003 after 5 edges.
- a=0x7FFF, b=0x0001, carry_in=0 → sum=0x8000 in both builds; overflow=1 with SIGNED_OVF_EN, overflow=0 without.
